key_debounce_scan: RTL and testbench
====================================

// Module: key_debounce_scan
// PURPOSE
//  Time-multiplexed debouncer between the raw keyboard switch pins and the SPI key-register stage.
//  Synchronises all key inputs and visits one key per scan tick, using a per-key saturating counter.
//  Drives a debounced pressed=1 vector to the SPI stage, plus a valid/ready FIFO of press/release events.
// PARAMETERS
//  NUM_KEYS      61  number of key inputs (2..512)
//  TICK_DIV      16  clk cycles per scan step (>=1); each key is revisited every NUM_KEYS*TICK_DIV cycles
//  DEBOUNCE_CNT  7   consecutive differing samples required to flip a key (1..255)
//  FIFO_DEPTH    4   event FIFO entries (power of 2, >=2)
//  ACTIVE_LOW    1   1: pin low = pressed; 0: pin high = pressed
// PORTS
//  clk_g_i        in   1              system clock
//  rstn_g_i       in   1              asynchronous active-low reset
//  keys_i_g       in   NUM_KEYS       raw asynchronous key pins
//  keys_o         out  NUM_KEYS       debounced state, 1 = pressed
//  evt_valid_o    out  1              event FIFO not empty
//  evt_ready_i    in   1              consumer pops the head entry when evt_valid_o=1
//  evt_key_o      out  KEY_W          head event key index, KEY_W=max(1,$clog2(NUM_KEYS))
//  evt_pressed_o  out  1              head event: 1 = press, 0 = release
//  overflow_o     out  1              sticky flag: an event was dropped
//  clr_ovf_i      in   1              synchronous clear of overflow_o
// BEHAVIOUR
//  Reset (async, rstn_g_i=0) clears everything:
//   - keys_o=0, all counters=0, scan index=0, prescaler=0, FIFO empty (evt_valid_o=0).
//   - evt_key_o=0, evt_pressed_o=0, overflow_o=0.
//   - Synchroniser flops reset to the not-pressed pin level.
//  Synchroniser: 2 flops per key; raw = sync[idx] XOR ACTIVE_LOW (1 = pressed).
//  Prescaler counts 0..TICK_DIV-1. tick=1 in the cycle where prescaler==TICK_DIV-1, and prescaler wraps to 0.
//  On tick, for key idx:
//   - raw==keys_o[idx]: cnt[idx] <= 0.
//   - otherwise, if cnt[idx]+1 == DEBOUNCE_CNT: keys_o[idx] <= raw, cnt[idx] <= 0, push event {idx, raw}.
//   - otherwise: cnt[idx] <= cnt[idx]+1.
//   - Then idx <= (idx==NUM_KEYS-1) ? 0 : idx+1. Keys are never skipped.
//  Counters: width $clog2(DEBOUNCE_CNT+1); they cannot exceed DEBOUNCE_CNT-1.
//   Any agreeing sample (bounce) resets the counter to 0.
//  Latency: the keys_o bit and evt_valid_o both update at the clock edge that ends the tick cycle.
//   Total latency from a pin edge is at most 2 sync cycles + DEBOUNCE_CNT*NUM_KEYS*TICK_DIV cycles.
//  FIFO:
//   - Pop when evt_valid_o && evt_ready_i. Head outputs are held stable while valid && !ready.
//   - Push while full and no pop: event dropped, overflow_o <= 1, keys_o still updates.
//   - Push while full with a simultaneous pop: the push is accepted, with no overflow.
//   - Push while empty with evt_ready_i=1: the new entry is not popped that cycle.
//   - clr_ovf_i clears overflow_o. If it coincides with a drop, overflow_o stays 1 (set wins).
//   - evt_key_o/evt_pressed_o are don't-care while evt_valid_o=0. The bench drives them to 0.
//  No combinational path from any input to any output.
// TESTING
//  Use NUM_KEYS=8, TICK_DIV=2, DEBOUNCE_CNT=3, FIFO_DEPTH=4, ACTIVE_LOW=1. Scan period is 16 cycles.
//  1 Reset with all pins=1, run 200 cycles -> keys_o=8'h00, evt_valid_o=0, overflow_o=0.
//  2 Pin 5 driven 0 and held -> keys_o[5]=1 within 2+3*16 cycles.
//     Required: exactly one event {key=5, pressed=1}; keys_o and evt_valid_o rise at the same edge.
//  3 Pin 2 toggles every 20 cycles for 400 cycles (never stable for 3 samples) -> keys_o[2] stays 0, no event.
//  4 Hold evt_ready_i=0; press keys 0,1,2,3,4 in turn ->
//     Required: the FIFO holds 4 events and the 5th sets overflow_o=1; keys_o=8'h1F.
//     Then pulse clr_ovf_i -> overflow_o=0.
//  5 FIFO full with evt_ready_i=1 on the cycle a new event is pushed -> count stays 4, overflow_o=0.
//     Required: pop order preserved (0,1,2,3, then new key).
//  6 Assert rstn_g_i=0 mid-debounce with pin 7 low and cnt[7]=2 -> all outputs cleared immediately.
//     After release, keys_o[7] rises only after 3 fresh samples.

Source files
------------

// File: rtl/key_debounce_scan.sv
// Time-multiplexed key debouncer. A 2-flop synchroniser feeds a round-robin scan that
// visits one key per tick, and a press/release event FIFO tracks the debounced key changes.
module key_debounce_scan #(
  parameter int unsigned  NUM_KEYS     = 61,
  parameter int unsigned  TICK_DIV     = 16,
  parameter int unsigned  DEBOUNCE_CNT = 7,
  parameter int unsigned  FIFO_DEPTH   = 4,
  parameter bit           ACTIVE_LOW   = 1'b1,
  localparam int unsigned KEY_W        = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk_g_i,
  input  logic                rstn_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [KEY_W-1:0]    evt_key_o,
  output logic                evt_pressed_o,
  output logic                overflow_o,
  input  logic                clr_ovf_i
);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [NUM_KEYS-1:0] IDLE_LVL = ACTIVE_LOW ? '1 : '0;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, raw;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick;
  logic [KEY_W-1:0]    idx_q, idx_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_inc;
  logic                raw_bit;
  logic                push;

  logic [KEY_W-1:0]      fifo_key_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_prs_q;
  logic [PTR_W-1:0]      wr_q, rd_q;
  logic [FILL_W-1:0]     fill_q;
  logic                  full, pop, push_ok, drop, ovf_q;

  // raw is 1 = pressed regardless of pin polarity
  assign raw     = sync2_q ^ IDLE_LVL;
  assign tick    = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d   = tick ? '0 : pre_q + PRE_W'(1);
  assign raw_bit = raw[idx_q];
  assign cnt_inc = cnt_q[idx_q] + CNT_W'(1);

  always_comb begin
    keys_d = keys_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    push   = 1'b0;
    if (tick) begin
      if (raw_bit == keys_q[idx_q]) begin
        cnt_d[idx_q] = '0;
      end else if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
        keys_d[idx_q] = raw_bit;
        cnt_d[idx_q]  = '0;
        push          = 1'b1;
      end else begin
        cnt_d[idx_q] = cnt_inc;
      end
      idx_d = (idx_q == KEY_W'(NUM_KEYS - 1)) ? '0 : idx_q + KEY_W'(1);
    end
  end

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      pre_q   <= '0;
      idx_q   <= '0;
      keys_q  <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= keys_i_g;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      keys_q  <= keys_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted then
  assign full    = (fill_q == FILL_W'(FIFO_DEPTH));
  assign pop     = (fill_q != '0) && evt_ready_i;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_key_q[i] <= '0;
      fifo_prs_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_key_q[wr_q] <= idx_q;
        fifo_prs_q[wr_q] <= raw_bit;
        wr_q             <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      if (push_ok && !pop)      fill_q <= fill_q + FILL_W'(1);
      else if (pop && !push_ok) fill_q <= fill_q - FILL_W'(1);
      if (drop)           ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign keys_o        = keys_q;
  assign evt_valid_o   = (fill_q != '0);
  assign evt_key_o     = evt_valid_o ? fifo_key_q[rd_q] : '0;
  assign evt_pressed_o = evt_valid_o & fifo_prs_q[rd_q];
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan: directed scenarios with literal expectations plus a
// per-cycle comparison against a tick-schedule/queue model of the debouncer.
module tb_key_debounce_scan;
  localparam int NK = 8;
  localparam int TD = 2;
  localparam int DB = 3;
  localparam int FD = 4;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic [NK-1:0] pins  = '1;
  logic          ready = 1'b0;
  logic          clr   = 1'b0;
  logic [NK-1:0] keys_o;
  logic          evt_valid, evt_prs, ovf;
  logic [2:0]    evt_key;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  key_debounce_scan #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .DEBOUNCE_CNT(DB), .FIFO_DEPTH(FD), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_g_i(clk), .rstn_g_i(rstn), .keys_i_g(pins), .keys_o(keys_o),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_key_o(evt_key),
    .evt_pressed_o(evt_prs), .overflow_o(ovf), .clr_ovf_i(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: edge n after reset is a scan tick when n%TD==TD-1, visiting key (n/TD)%NK.
  typedef struct { int key; bit prs; } ev_t;
  ev_t           m_q[$];
  logic [NK-1:0] m_keys, m_h1, m_h2;
  int            m_run [NK];
  int            m_cyc;
  bit            m_ovf;

  task automatic model_reset();
    m_keys = '0;
    m_h1   = '1;
    m_h2   = '1;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    m_cyc = 0;
    m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit            pop_now, push_now, lost, pr;
    ev_t           ev;
    logic [NK-1:0] samp;
    int            k;
    pop_now  = (m_q.size() != 0) && (ready == 1'b1);
    push_now = 1'b0;
    ev       = '{0, 1'b0};
    samp     = m_h2;
    m_h2     = m_h1;
    m_h1     = pins;
    if (m_cyc % TD == TD - 1) begin
      k  = (m_cyc / TD) % NK;
      pr = (samp[k] == 1'b0);
      if (pr == m_keys[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_run[k]  = 0;
          m_keys[k] = pr;
          push_now  = 1'b1;
          ev        = '{k, pr};
        end
      end
    end
    m_cyc++;
    lost = push_now && (m_q.size() == FD) && !pop_now;
    if (pop_now) void'(m_q.pop_front());
    if (push_now && !lost) m_q.push_back(ev);
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  function automatic bit push_pending();
    int k;
    if (m_cyc % TD != TD - 1) return 1'b0;
    k = (m_cyc / TD) % NK;
    return ((m_h2[k] == 1'b0) != m_keys[k]) && (m_run[k] + 1 == DB);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_keys", 32'(keys_o), 32'(m_keys));
      check("cmp_valid", 32'(evt_valid), 32'(m_q.size() != 0));
      check("cmp_ovf", 32'(ovf), 32'(m_ovf));
      if (m_q.size() != 0) begin
        check("cmp_key", 32'(evt_key), 32'(m_q[0].key));
        check("cmp_prs", 32'(evt_prs), 32'(m_q[0].prs));
      end else begin
        check("cmp_key_idle", 32'(evt_key), 32'd0);
        check("cmp_prs_idle", 32'(evt_prs), 32'd0);
      end
    end
  end

  task automatic wait_key(input int k, input int budget, output int waited, output bit ok);
    ok     = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      @(negedge clk);
      waited++;
      if (keys_o[k] === 1'b1) ok = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    bit ok;
    int exp_k [4];
    bit exp_p [4];
    exp_k = '{1, 2, 3, 4};
    exp_p = '{1'b1, 1'b1, 1'b1, 1'b0};

    // 1: reset with all pins released
    repeat (3) @(negedge clk);
    rstn   = 1'b1;
    cmp_en = 1'b1;
    repeat (200) @(negedge clk);
    check("t1_keys", 32'(keys_o), 32'h00);
    check("t1_valid", 32'(evt_valid), 32'd0);
    check("t1_ovf", 32'(ovf), 32'd0);

    // 2: single press of key 5
    pins[5] = 1'b0;
    wait_key(5, 60, waited, ok);
    check("t2_found", 32'(ok), 32'd1);
    check("t2_latency_le_50", 32'(waited <= 2 + DB * NK * TD), 32'd1);
    check("t2_keys", 32'(keys_o), 32'h20);
    check("t2_valid_same_edge", 32'(evt_valid), 32'd1);
    check("t2_key", 32'(evt_key), 32'd5);
    check("t2_prs", 32'(evt_prs), 32'd1);
    repeat (48) @(negedge clk);
    check("t2_head_held", 32'(evt_key), 32'd5);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t2_popped", 32'(evt_valid), 32'd0);
    repeat (48) @(negedge clk);
    check("t2_single_event", 32'(evt_valid), 32'd0);
    pins[5] = 1'b1;
    ready   = 1'b1;
    repeat (80) @(negedge clk);
    check("t2_released", 32'(keys_o), 32'h00);
    check("t2_drained", 32'(evt_valid), 32'd0);

    // 3: key 2 bouncing every 20 cycles never settles
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pins[2] = ~pins[2];
      repeat (20) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    check("t3_keys", 32'(keys_o), 32'h00);
    check("t3_no_event", 32'(evt_valid), 32'd0);

    // 4: five presses with the consumer stalled
    for (int k = 0; k < 5; k++) begin
      pins[k] = 1'b0;
      wait_key(k, 60, waited, ok);
      check("t4_found", 32'(ok), 32'd1);
    end
    check("t4_ovf", 32'(ovf), 32'd1);
    check("t4_keys", 32'(keys_o), 32'h1F);
    check("t4_head_key", 32'(evt_key), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4_ovf_cleared", 32'(ovf), 32'd0);

    // 5: release of key 4 pushed while full, with a pop on the same edge
    pins[4] = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (push_pending()) ok = 1'b1;
    end
    check("t5_push_seen", 32'(ok), 32'd1);
    check("t5_head_before", 32'(evt_key), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t5_no_ovf", 32'(ovf), 32'd0);
    check("t5_keys", 32'(keys_o), 32'h0F);
    for (int i = 0; i < 4; i++) begin
      check("t5_order_valid", 32'(evt_valid), 32'd1);
      check("t5_order_key", 32'(evt_key), 32'(exp_k[i]));
      check("t5_order_prs", 32'(evt_prs), 32'(exp_p[i]));
      ready = 1'b1;
      @(negedge clk);
    end
    check("t5_empty", 32'(evt_valid), 32'd0);

    // 6: reset in the middle of key 7 debouncing
    pins[7] = 1'b0;
    ok      = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m_run[7] == 2) ok = 1'b1;
    end
    check("t6_cnt2_seen", 32'(ok), 32'd1);
    check("t6_keys_before", 32'(keys_o), 32'h0F);
    #2 rstn = 1'b0;
    #1;
    check("t6_keys_cleared", 32'(keys_o), 32'h00);
    check("t6_valid_cleared", 32'(evt_valid), 32'd0);
    check("t6_ovf_cleared", 32'(ovf), 32'd0);
    check("t6_key_cleared", 32'(evt_key), 32'd0);
    check("t6_prs_cleared", 32'(evt_prs), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (47) @(negedge clk);
    check("t6_key7_not_yet", 32'(keys_o[7]), 32'd0);
    @(negedge clk);
    check("t6_key7_third_sample", 32'(keys_o[7]), 32'd1);
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
